// File: rtl/pif_led_pkg.sv
// pif_led_pkg -- shared definitions for the flasher-board LED sequencer.
//
// Holds the LED mode encoding that the control-register block writes
// and the sequencer decodes, plus the small enums used for the blink
// phase and the breathe ramp direction.
//
// Optional feature macro: PIF_LED_BREATHE_EN (affects pif_led_seq only).
//
// Contents:
//   MODE_W                                   width of the LED mode field (2)
//   led_mode_t                               LED mode type
//   LED_OFF / LED_ALTERNATING / LED_SYNC / LED_BREATHE   mode constants
//   phase_e                                  blink phase (A / B)
//   dir_e                                    breathe ramp direction
//   blink_decode()                           {r,g} for the blink modes

package pif_led_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] led_mode_t;

    localparam led_mode_t LED_OFF         = 2'd0;
    localparam led_mode_t LED_ALTERNATING = 2'd1;
    localparam led_mode_t LED_SYNC        = 2'd2;
    localparam led_mode_t LED_BREATHE     = 2'd3;

    typedef enum logic {
        PHASE_A = 1'b0,
        PHASE_B = 1'b1
    } phase_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Returns {red, green} for the phase-driven modes. Every other mode
    // (OFF, and BREATHE which is handled separately) decodes to dark.
    function automatic logic [1:0] blink_decode(input led_mode_t m, input phase_e ph);
        logic [1:0] rg;
        rg = 2'b00;
        case (m)
            LED_ALTERNATING: rg = (ph == PHASE_A) ? 2'b10 : 2'b01;
            LED_SYNC:        rg = (ph == PHASE_A) ? 2'b11 : 2'b00;
            default:         rg = 2'b00;
        endcase
        return rg;
    endfunction

endpackage

// File: rtl/pif_led_seq_tick_div.sv
// pif_tick_div -- prescaler producing the sequencer time base.
//
// Counts 0..PRESCALE-1 on every clock and wraps. `wrap` is the
// combinational strobe for the cycle in which the counter sits on its
// last value (the same edge that wraps it advances the consumers);
// `tick` is the registered copy of that strobe, visible one cycle later.
// A synchronous clear returns the counter to 0 and suppresses the tick,
// so a wrap coinciding with a clear is dropped.
//
// Ports:
//   clk   in  1  rising-edge clock
//   clr   in  1  synchronous clear (reset or mode restart)
//   wrap  out 1  combinational wrap strobe, 0 while clr is high
//   tick  out 1  registered one-cycle tick strobe

module pif_tick_div #(
    parameter int PRESCALE = 12000
) (
    input  logic clk,
    input  logic clr,
    output logic wrap,
    output logic tick
);

    localparam int P_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [P_W-1:0] P_LAST = P_W'(PRESCALE - 1);

    logic [P_W-1:0] p;

    assign wrap = (p == P_LAST) && !clr;

    always_ff @(posedge clk) begin
        if (clr) begin
            p    <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                p <= '0;
            end else begin
                p <= p + P_W'(1);
            end
        end
    end

endmodule

// File: rtl/pif_led_seq.sv
// pif_led_seq -- red/green LED sequencer for the flasher board.
//
// Turns the 2-bit LED mode from the control register into registered
// drive for the two LEDs: OFF, ALTERNATING, SYNC blink and, when the
// macro PIF_LED_BREATHE_EN is defined, a PWM "breathe" triangle ramp.
// Without the macro the PWM/duty/direction registers are not built and
// mode 3 decodes as dark (it still restarts the sequence when selected).
//
// Any change of `mode` restarts the sequence: prescaler, half-phase
// counter, phase and the breathe ramp return to their reset values in
// the same cycle that mode_q latches the new mode, and a tick falling
// on that cycle is dropped. The PWM counter is free-running and is only
// cleared by rst.
//
// Ports:
//   xclk   in  1  oscillator clock, rising edge
//   rst    in  1  synchronous active-high reset
//   mode   in  2  LED mode (0 OFF, 1 ALTERNATING, 2 SYNC, 3 BREATHE)
//   led_r  out 1  red LED drive, active-high, registered
//   led_g  out 1  green LED drive, active-high, registered
//   tick   out 1  one-cycle prescaler wrap strobe, registered

module pif_led_seq
    import pif_led_pkg::*;
#(
    parameter int PRESCALE   = 12000,
    parameter int HALF_TICKS = 250,
    parameter int PWM_W      = 6
) (
    input  logic              xclk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode,
    output logic              led_r,
    output logic              led_g,
    output logic              tick
);

    if (PRESCALE < 2 || HALF_TICKS < 1 || PWM_W < 1) begin : g_bad_params
        $error("pif_led_seq: illegal PRESCALE/HALF_TICKS/PWM_W");
    end

    localparam int H_W = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
    localparam logic [H_W-1:0] H_LAST = H_W'(HALF_TICKS - 1);

    led_mode_t mode_q;
    logic      mode_change;
    logic      clr;
    logic      wrap;

    assign mode_change = (mode != mode_q);
    assign clr         = rst | mode_change;

    pif_tick_div #(
        .PRESCALE(PRESCALE)
    ) u_tick_div (
        .clk  (xclk),
        .clr  (clr),
        .wrap (wrap),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Blink phase FSM. The half-phase counter advances on the wrap edge,
    // so a phase lasts exactly PRESCALE*HALF_TICKS cycles from a restart.
    // ------------------------------------------------------------------
    logic [H_W-1:0] h;
    logic [H_W-1:0] h_next;
    phase_e         phase;
    phase_e         phase_next;

    always_comb begin
        h_next     = h;
        phase_next = phase;
        if (wrap) begin
            if (h == H_LAST) begin
                h_next     = '0;
                phase_next = (phase == PHASE_A) ? PHASE_B : PHASE_A;
            end else begin
                h_next = h + H_W'(1);
            end
        end
        if (mode_q == LED_OFF) begin
            phase_next = PHASE_A;
        end
    end

    always_ff @(posedge xclk) begin
        if (rst) begin
            mode_q <= LED_OFF;
            h      <= '0;
            phase  <= PHASE_A;
        end else if (mode_change) begin
            mode_q <= mode;
            h      <= '0;
            phase  <= PHASE_A;
        end else begin
            h      <= h_next;
            phase  <= phase_next;
        end
    end

    // ------------------------------------------------------------------
    // Breathe ramp: triangle on duty with a one-tick dwell at each end,
    // compared against a free-running PWM counter.
    // ------------------------------------------------------------------
    logic breathe_on;

`ifdef PIF_LED_BREATHE_EN
    localparam logic [PWM_W-1:0] DUTY_MAX = '1;

    logic [PWM_W-1:0] pwm;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] duty_next;
    dir_e             dir;
    dir_e             dir_next;

    always_comb begin
        duty_next = duty;
        dir_next  = dir;
        if (wrap) begin
            if (dir == DIR_UP) begin
                if (duty == DUTY_MAX) begin
                    dir_next = DIR_DOWN;
                end else begin
                    duty_next = duty + PWM_W'(1);
                end
            end else begin
                if (duty == '0) begin
                    dir_next = DIR_UP;
                end else begin
                    duty_next = duty - PWM_W'(1);
                end
            end
        end
    end

    always_ff @(posedge xclk) begin
        if (rst) begin
            pwm <= '0;
        end else begin
            pwm <= pwm + PWM_W'(1);
        end
        if (clr) begin
            duty <= '0;
            dir  <= DIR_UP;
        end else begin
            duty <= duty_next;
            dir  <= dir_next;
        end
    end

    assign breathe_on = (pwm < duty);
`else
    assign breathe_on = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output decode, registered from the current mode_q/phase/ramp state.
    // ------------------------------------------------------------------
    logic [1:0] rg_next;

    always_comb begin
        rg_next = 2'b00;
        if (mode_q == LED_BREATHE) begin
            rg_next = {breathe_on, breathe_on};
        end else begin
            rg_next = blink_decode(mode_q, phase);
        end
    end

    always_ff @(posedge xclk) begin
        if (rst) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
        end else begin
            led_r <= rg_next[1];
            led_g <= rg_next[0];
        end
    end

endmodule

// File: tb/tb_pif_led_seq.sv
// tb_pif_led_seq -- directed self-checking bench for pif_led_seq with
// PRESCALE=4, HALF_TICKS=3, PWM_W=3. Builds with or without the
// PIF_LED_BREATHE_EN macro; mode 3 is checked in whichever form is built.
//
// Timing reference used by the expectations: "edge n" is the edge that
// latches a new mode (restart). k counts edges after n; outputs are
// sampled 1 time unit after each edge.
//   tick  after edge n+k : (k % 4 == 0), k >= 1
//   phase after edge n+m : A when (m/12) is even
//   LEDs  after edge n+k : decoded from the state after edge n+k-1

module tb_pif_led_seq;

    logic       xclk;
    logic       rst;
    logic [1:0] mode;
    logic       led_r;
    logic       led_g;
    logic       tick;

    int tests_run    = 0;
    int tests_failed = 0;

    pif_led_seq #(
        .PRESCALE   (4),
        .HALF_TICKS (3),
        .PWM_W      (3)
    ) dut (
        .xclk  (xclk),
        .rst   (rst),
        .mode  (mode),
        .led_r (led_r),
        .led_g (led_g),
        .tick  (tick)
    );

    // Clock / reset block
    initial begin
        xclk = 1'b0;
        forever #5 xclk = ~xclk;
    end

    initial begin
        rst  = 1'b1;
        mode = 2'd0;
    end

    // Driver: advance one edge and settle before sampling.
    task automatic step();
        @(posedge xclk);
        #1;
    endtask

    // Triangle with end dwell for an 8-level duty: ticks 0..7 ramp up,
    // tick 8 holds at 7, 9..15 ramp down, tick 16 holds at 0.
    function automatic int duty_at(input int t);
        int u;
        u = t % 16;
        return (u <= 7) ? u : (15 - u);
    endfunction

    task automatic test_reset();
        rst  = 1'b1;
        mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({led_r, led_g, tick} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle=%0d got r=%b g=%b t=%b expected 000", i, led_r, led_g, tick);
            end
        end
        rst = 1'b0;
        // Restart edge: mode_q still OFF when the LEDs are decoded.
        step();
        tests_run++;
        if ({led_r, led_g, tick} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_restart_edge got r=%b g=%b t=%b expected 000", led_r, led_g, tick);
        end
    endtask

    // Checks k = 1..n_cycles after a restart into ALTERNATING.
    task automatic check_alt(input string name, input int n_cycles);
        logic exp_r;
        logic exp_g;
        logic exp_t;
        for (int k = 1; k <= n_cycles; k++) begin
            step();
            exp_r = (((k - 1) / 12) % 2) == 0;
            exp_g = !exp_r;
            exp_t = (k % 4) == 0;
            tests_run++;
            if ({led_r, led_g, tick} !== {exp_r, exp_g, exp_t}) begin
                tests_failed++;
                $display("FAIL %s k=%0d got r=%b g=%b t=%b expected r=%b g=%b t=%b",
                         name, k, led_r, led_g, tick, exp_r, exp_g, exp_t);
            end
        end
    endtask

    task automatic check_sync(input string name, input int n_cycles);
        logic exp_on;
        logic exp_t;
        for (int k = 1; k <= n_cycles; k++) begin
            step();
            exp_on = (((k - 1) / 12) % 2) == 0;
            exp_t  = (k % 4) == 0;
            tests_run++;
            if ({led_r, led_g, tick} !== {exp_on, exp_on, exp_t}) begin
                tests_failed++;
                $display("FAIL %s k=%0d got r=%b g=%b t=%b expected r=%b g=%b t=%b",
                         name, k, led_r, led_g, tick, exp_on, exp_on, exp_t);
            end
        end
    endtask

    task automatic test_alternating();
        // Continues directly from the restart taken in test_reset.
        check_alt("alternating", 36);
    endtask

    task automatic test_sync();
        mode = 2'd2;
        step();  // restart edge
        check_sync("sync", 30);
    endtask

    task automatic test_mode_change();
        mode = 2'd1;
        step();  // restart edge into ALTERNATING
        check_alt("mc_alt_pre", 19);  // k=19 is cycle 7 of phase B
        mode = 2'd2;
        step();  // restart edge; a tick would have fallen here
        tests_run++;
        if ({led_r, led_g, tick} !== 3'b010) begin
            tests_failed++;
            $display("FAIL mode_change_edge got r=%b g=%b t=%b expected r=0 g=1 t=0", led_r, led_g, tick);
        end
        check_sync("mc_sync_post", 24);
    endtask

`ifdef PIF_LED_BREATHE_EN
    task automatic test_breathe();
        logic exp_on;
        logic exp_t;
        // Reset aligns the free-running PWM: after restart edge n+k the
        // PWM value used for the LED decode is k % 8.
        rst  = 1'b1;
        mode = 2'd3;
        step();
        step();
        rst = 1'b0;
        step();  // restart edge
        tests_run++;
        if ({led_r, led_g, tick} !== 3'b000) begin
            tests_failed++;
            $display("FAIL breathe_restart_edge got r=%b g=%b t=%b expected 000", led_r, led_g, tick);
        end
        for (int k = 1; k <= 72; k++) begin
            step();
            exp_on = (k % 8) < duty_at((k - 1) / 4);
            exp_t  = (k % 4) == 0;
            tests_run++;
            if ({led_r, led_g, tick} !== {exp_on, exp_on, exp_t}) begin
                tests_failed++;
                $display("FAIL breathe k=%0d got r=%b g=%b t=%b expected r=%b g=%b t=%b",
                         k, led_r, led_g, tick, exp_on, exp_on, exp_t);
            end
        end
    endtask
`else
    task automatic test_mode3_off();
        logic exp_t;
        mode = 2'd3;
        step();  // restart edge
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_t = (k % 4) == 0;
            tests_run++;
            if ({led_r, led_g, tick} !== {1'b0, 1'b0, exp_t}) begin
                tests_failed++;
                $display("FAIL mode3_dark k=%0d got r=%b g=%b t=%b expected r=0 g=0 t=%b",
                         k, led_r, led_g, tick, exp_t);
            end
        end
        mode = 2'd1;
        step();  // restart edge
        check_alt("mode3_to_alt", 26);
    endtask
`endif

    task automatic test_reset_mid();
        mode = 2'd2;
        step();
        check_sync("pre_reset_sync", 5);
        rst = 1'b1;
        step();
        tests_run++;
        if ({led_r, led_g, tick} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_reset got r=%b g=%b t=%b expected 000", led_r, led_g, tick);
        end
        rst = 1'b0;
        step();  // restart edge, mode_q was reset to OFF
        tests_run++;
        if ({led_r, led_g, tick} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mid_reset_restart got r=%b g=%b t=%b expected 000", led_r, led_g, tick);
        end
        check_sync("post_reset_sync", 14);
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_sync();
        test_mode_change();
`ifdef PIF_LED_BREATHE_EN
        test_breathe();
`else
        test_mode3_off();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
